// File: rtl/rvfi_retire_fifo_if.sv
// Retirement capture bus: RVFI record inputs, control strobes and the valid/ready drain port.
// The producer and consumer side uses the master modport; the FIFO uses slave.
interface rvfi_retire_fifo_if #(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NRET-1:0]      rvfi_valid;
    logic [64*NRET-1:0]   rvfi_order;
    logic [ILEN*NRET-1:0] rvfi_insn;
    logic [NRET-1:0]      rvfi_trap;
    logic [XLEN*NRET-1:0] rvfi_pc_rdata;
    logic [XLEN*NRET-1:0] rvfi_pc_wdata;
    logic [5*NRET-1:0]    rvfi_rd_addr;
    logic [XLEN*NRET-1:0] rvfi_rd_wdata;
    logic                 flush;
    logic                 clear_err;
    logic                 out_ready;
    logic                 out_valid;
    logic [63:0]          out_order;
    logic [ILEN-1:0]      out_insn;
    logic                 out_trap;
    logic [XLEN-1:0]      out_pc_rdata;
    logic [XLEN-1:0]      out_pc_wdata;
    logic [4:0]           out_rd_addr;
    logic [XLEN-1:0]      out_rd_wdata;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 order_err;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, flush, clear_err, out_ready,
        input  out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata,
               out_rd_addr, out_rd_wdata, count, overflow, order_err
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, flush, clear_err, out_ready,
        output out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata,
               out_rd_addr, out_rd_wdata, count, overflow, order_err
    );
endinterface

// File: rtl/rvfi_retire_fifo.sv
// Capture buffer for RVFI retirement: compacts up to NRET records per cycle into a circular
// buffer, checks rvfi_order continuity, and drains one record per cycle on valid/ready.
module rvfi_retire_fifo #(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    rvfi_retire_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } rec_t;

    rec_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q, order_err_q;
    logic [63:0]   exp_order;

    rec_t          in_rec [NRET];
    logic [PW-1:0] slot   [NRET];
    logic [CW-1:0] v_cnt;
    logic [63:0]   exp_next;
    logic          accept, pop, out_valid, ovf_set, err_set;
    rec_t          head;

    assign out_valid = (count_q != '0);

    always_comb begin
        v_cnt    = '0;
        exp_next = exp_order;
        err_set  = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            in_rec[k].order    = bus.rvfi_order[64*k +: 64];
            in_rec[k].insn     = bus.rvfi_insn[ILEN*k +: ILEN];
            in_rec[k].trap     = bus.rvfi_trap[k];
            in_rec[k].pc_rdata = bus.rvfi_pc_rdata[XLEN*k +: XLEN];
            in_rec[k].pc_wdata = bus.rvfi_pc_wdata[XLEN*k +: XLEN];
            in_rec[k].rd_addr  = bus.rvfi_rd_addr[5*k +: 5];
            in_rec[k].rd_wdata = bus.rvfi_rd_wdata[XLEN*k +: XLEN];
            // Slot = write pointer plus number of lower valid channels (compaction).
            slot[k] = wr_ptr + PW'(v_cnt);
            if (bus.rvfi_valid[k]) begin
                // NOTE: blocking updates here form a ripple through the channels; each
                // channel sees the running expected order left by the channel before it.
                if (bus.rvfi_order[64*k +: 64] != exp_next) err_set = 1'b1;
                exp_next = bus.rvfi_order[64*k +: 64] + 64'd1;
                v_cnt    = v_cnt + CW'(1);
            end
        end
        // Free space is judged on the registered count; a same-cycle pop does not help.
        accept  = (v_cnt <= (CW'(DEPTH) - count_q));
        ovf_set = !accept;
        pop     = out_valid && bus.out_ready;
    end

    // NOTE: the record storage is deliberately not reset; stale slots are never visible
    // because the output fields are masked whenever the buffer is empty.
    always_ff @(posedge clock) begin
        if (accept && !bus.flush) begin
            for (int k = 0; k < NRET; k++) begin
                if (bus.rvfi_valid[k]) mem[slot[k]] <= in_rec[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            exp_order   <= '0;
        end else begin
            exp_order   <= exp_next;
            overflow_q  <= ovf_set | (overflow_q & ~bus.clear_err);
            order_err_q <= err_set | (order_err_q & ~bus.clear_err);
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + PW'(v_cnt);
                if (pop)    rd_ptr <= rd_ptr + PW'(1);
                count_q <= count_q + (accept ? v_cnt : '0) - CW'(pop);
            end
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign bus.out_valid    = out_valid;
    assign bus.out_order    = head.order;
    assign bus.out_insn     = head.insn;
    assign bus.out_trap     = head.trap;
    assign bus.out_pc_rdata = head.pc_rdata;
    assign bus.out_pc_wdata = head.pc_wdata;
    assign bus.out_rd_addr  = head.rd_addr;
    assign bus.out_rd_wdata = head.rd_wdata;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.order_err    = order_err_q;
endmodule

// File: doc/rvfi_retire_fifo.md
# rvfi_retire_fifo

Parametrised capture buffer for RVFI retirement traffic. It sits between a core's `RVFI_OUTPUTS` and a trace consumer such as a bench scoreboard, a trace port or a waveform logger. Each cycle it accepts up to NRET retired-instruction records, compacts them in channel order, and checks that `rvfi_order` is contiguous. It then presents the records one at a time on a valid/ready drain port, with sticky overflow and order-error flags.

## Interface
Parameters:
- NRET, 1: retire channels per cycle (1..4).
- XLEN, 32: data/PC width.
- ILEN, 32: instruction width.
- DEPTH, 8: entries; power of two, at least 2, at least NRET.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rvfi_valid  in  NRET  per-channel retire strobe.
- rvfi_order  in  64*NRET  per-channel order; channel k at bits [64k+63:64k] (same packing for all channel buses).
- rvfi_insn  in  ILEN*NRET  instruction word.
- rvfi_trap  in  NRET  trap flag.
- rvfi_pc_rdata, rvfi_pc_wdata  in  XLEN*NRET  PC before/after.
- rvfi_rd_addr  in  5*NRET  destination register.
- rvfi_rd_wdata  in  XLEN*NRET  destination data.
- flush  in  1  synchronous clear of buffered entries.
- clear_err  in  1  synchronous clear of sticky flags.
- out_ready  in  1  consumer accepts head entry.
- out_valid  out  1  head entry present.
- out_order  out  64  order field of the head entry.
- out_insn  out  ILEN  instruction field of the head entry.
- out_trap  out  1  trap field of the head entry.
- out_pc_rdata, out_pc_wdata  out  XLEN  PC fields of the head entry.
- out_rd_addr  out  5  destination-register field of the head entry.
- out_rd_wdata  out  XLEN  destination-data field of the head entry.
- count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky: a retire batch was dropped.
- order_err  out  1  sticky: order discontinuity seen.

## Operation
Storage:
- Circular buffer of DEPTH records.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Push:
- Let V = popcount(rvfi_valid).
- Valid channels are written in ascending channel index to consecutive slots starting at the write pointer.
- The write pointer then advances by V.

Capacity:
- The batch is accepted only if V is at most DEPTH minus count.
- A pop in the same cycle does not free a slot for that cycle's push.
- Otherwise the whole batch is dropped, with no partial write, and overflow sets.

Pop:
- Occurs when out_valid and out_ready are both high.
- The read pointer advances by 1.
- count_next = count + accepted V - pop.

Order check:
- Register exp_order (64 bits) resets to 0.
- Valid channels are checked in ascending index, whether the batch is accepted or dropped.
- For each valid channel: if its order is not equal to the running expected value, order_err sets.
- The running expected value then becomes that channel's order + 1 (resynchronise), and the next valid channel is checked against it.
- exp_order holds the final value at cycle end.
- Arithmetic is modulo 2^64.

Flush:
- Sets count to 0 and equates the pointers.
- Any same-cycle push and pop are discarded.
- The order check still runs on the flushed batch.
- Sticky flags and exp_order are unaffected.

Clear_err:
- Clears overflow and order_err.
- A same-cycle setting event wins, so the flag reads 1 the next cycle.

Output:
- out_valid = (count != 0).
- out_* fields show the entry at the read pointer.
- All out_* data fields are forced to 0 while out_valid is low.

## Timing
- Reset (async assert, sync-to-clock release) values: count=0, out_valid=0, all out_* fields 0, overflow=0, order_err=0, pointers=0, exp_order=0.
- Reset asserted mid-operation discards all entries immediately.
- Latency: a record pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1 when the FIFO was empty.
- There is no combinational path from the rvfi_* inputs to out_*.
- out_ready may toggle freely. Once raised, out_valid stays high until a pop; the fields are stable until that pop.
- Throughput: 1 pop per cycle and up to NRET pushes per cycle.
- Sustained NRET > 1 retirement therefore fills the buffer.
- count, overflow and order_err are registered and update one edge after the causing event.
- Full and empty boundaries: with count=DEPTH, any V≥1 drops the batch even if a pop occurs that cycle. With count=0, a pop is impossible because out_valid is low.

## Test plan
- Reset then idle: after reset_n release, count=0, out_valid=0, out_order=0, overflow=0 and order_err=0 for 10 cycles.
- NRET=1, DEPTH=8, out_ready=0, push orders 0..7: count reaches 8. A ninth push (order 8) sets overflow, count stays 8, and order_err stays 0. Then out_ready=1 drains orders 0..7 in sequence, one per cycle.
- NRET=2, valid=2'b10 with order 0, then valid=2'b11 with orders 1,2: entries drain as 0,1,2 and count peaks at 3.
- Order gap: push orders 0,1,3. order_err sets in the cycle after order 3 is pushed; a following order 4 raises no new error. Clear_err then gives order_err=0.
- Wrap-around: DEPTH=4 with continuous push/pop for 20 records: output orders equal input orders 0..19 and there is no overflow.
- Flush with a simultaneous push of order 5 while count=3: next cycle count=0 and out_valid=0. A following push of order 6 raises no order_err.
